// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 decode/execute types, opcodes and pipe occupancy enum
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Decoded instruction handed from decode to execute (160 bits, pc in the MSBs)
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } id_ex_t;

    // Number of instructions held between decode and execute
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/id_ex_skid_reg.sv
// rtl/id_ex_skid_reg.sv - ID/EX pipeline register with skid buffer and flush
module id_ex_skid_reg
    import rv32_pkg::*;
#(
    parameter bit CLEAR_ON_FLUSH = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  id_ex_t in_data,
    input  logic   flush,
    output logic   out_valid,
    input  logic   out_ready,
    output id_ex_t out_data
);

    occ_t   state;
    occ_t   state_nxt;
    id_ex_t main_q;
    id_ex_t skid_q;
    logic   in_ready_q;
    logic   accept;
    logic   consume;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign accept    = in_valid && in_ready_q;
    assign consume   = (state != OCC_EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state != OCC_EMPTY);
    assign out_data  = main_q;

    // Next occupancy; a redirect empties the pipe whatever else happens this cycle
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) state_nxt = OCC_ONE;
                OCC_ONE: begin
                    if (accept && !consume)      state_nxt = OCC_TWO;
                    else if (!accept && consume) state_nxt = OCC_EMPTY;
                end
                OCC_TWO:   if (consume) state_nxt = OCC_ONE;
                default:   state_nxt = OCC_EMPTY;
            endcase
        end
    end

    // Occupancy and the registered ready, which tracks the next occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != OCC_TWO);
        end
    end

    // Payload movement: main feeds execute, skid catches the one beat accepted while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            case (state)
                OCC_EMPTY: if (accept) main_q <= in_data;
                OCC_ONE: begin
                    if (accept && consume) main_q <= in_data;
                    else if (accept)       skid_q <= in_data;
                end
                OCC_TWO:   if (consume) main_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb/tb_id_ex_skid_reg.sv - directed and scoreboard checks for id_ex_skid_reg
module tb_id_ex_skid_reg;
    import rv32_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   in_valid;
    logic   flush;
    logic   out_ready;
    id_ex_t in_data;
    logic   ir0, ov0, ir1, ov1;
    id_ex_t od0, od1;

    int n_cmp = 0;
    int n_mis = 0;
    int seq   = 0;
    id_ex_t mq[$];
    logic acc, con;

    always #5 clk = ~clk;

    id_ex_skid_reg #(.CLEAR_ON_FLUSH(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .flush(flush), .out_valid(ov0), .out_ready(out_ready), .out_data(od0)
    );

    id_ex_skid_reg #(.CLEAR_ON_FLUSH(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
    );

    function automatic id_ex_t mk(input logic [31:0] pc, input logic [31:0] imm);
        id_ex_t d;
        d          = '0;
        d.pc       = pc;
        d.opcode   = OP_IMM;
        d.rd       = pc[6:2];
        d.rs1      = 5'd2;
        d.rs2      = 5'd3;
        d.funct3   = 3'd5;
        d.funct7   = 7'h20;
        d.imm      = imm;
        d.rs1_data = ~pc;
        d.rs2_data = pc ^ 32'hA5A5_A5A5;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Both instances share every behaviour except flush payload clearing
    task automatic chk_hs(input string tag, input logic ev, input logic er);
        chk({tag, "_v0"}, ov0, ev);
        chk({tag, "_r0"}, ir0, er);
        chk({tag, "_v1"}, ov1, ev);
        chk({tag, "_r1"}, ir1, er);
    endtask

    task automatic chk_data(input string tag, input id_ex_t ed);
        chk({tag, "_d0"}, od0, ed);
        chk({tag, "_d1"}, od1, ed);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        chk_hs("reset", 1'b0, 1'b1);
        chk_data("reset", '0);

        // offered during reset: must not be taken
        in_valid = 1'b1; out_ready = 1'b1; in_data = mk(32'h0, 32'hFFFF_FFFC);
        tick();
        chk_hs("in_reset", 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // stream of 8 with out_ready=1: one per cycle, latency 1
        for (int i = 0; i < 8; i++) begin
            in_data = mk(32'(i * 4), 32'hFFFF_FFFC);
            tick();
            chk_hs("stream", 1'b1, 1'b1);
            chk_data("stream", mk(32'(i * 4), 32'hFFFF_FFFC));
        end
        in_valid = 1'b0;
        tick();
        chk_hs("stream_drain", 1'b0, 1'b1);

        // stall with in_valid held
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h00, 32'h1);
        tick();
        chk_hs("stall1", 1'b1, 1'b1);
        chk_data("stall1", mk(32'h00, 32'h1));
        in_data = mk(32'h04, 32'h2);
        tick();
        chk_hs("stall2", 1'b1, 1'b0);
        chk_data("stall2", mk(32'h00, 32'h1));
        in_data = mk(32'h08, 32'h3);
        tick();
        chk_hs("stall3", 1'b1, 1'b0);
        chk_data("stall3", mk(32'h00, 32'h1));
        out_ready = 1'b1;
        tick();
        chk_hs("release1", 1'b1, 1'b1);
        chk_data("release1", mk(32'h04, 32'h2));
        tick();
        chk_hs("release2", 1'b1, 1'b1);
        chk_data("release2", mk(32'h08, 32'h3));
        in_valid = 1'b0;
        tick();
        chk_hs("release_drain", 1'b0, 1'b1);

        // flush while holding two, with an instruction offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h10, 32'h10);
        tick();
        in_data = mk(32'h14, 32'h14);
        tick();
        chk_hs("fill_two", 1'b1, 1'b0);
        in_data = mk(32'h40, 32'h40); flush = 1'b1;
        tick();
        chk_hs("flush", 1'b0, 1'b1);
        chk("flush_keep_d0", od0, mk(32'h10, 32'h10));
        chk("flush_clear_d1", od1, '0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk_hs("post_flush", 1'b0, 1'b1);
        in_valid = 1'b1; in_data = mk(32'h50, 32'h50);
        tick();
        chk_hs("after_flush", 1'b1, 1'b1);
        chk_data("after_flush", mk(32'h50, 32'h50));
        in_valid = 1'b0;
        tick();

        // asynchronous reset in the middle of a cycle while full
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h60, 32'h60);
        tick();
        in_data = mk(32'h64, 32'h64);
        tick();
        chk_hs("fill_two_b", 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_hs("async_rst", 1'b0, 1'b1);
        chk_data("async_rst", '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_hs("after_rst", 1'b0, 1'b1);

        // random traffic against a queue model
        mq.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            seq++;
            in_data   = mk(32'(seq * 4), $urandom());
            acc = in_valid && (mq.size() < 2);
            con = out_ready && (mq.size() != 0);
            tick();
            if (flush) begin
                mq.delete();
            end else begin
                if (con) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
            end
            chk_hs("rnd", mq.size() != 0, mq.size() != 2);
            if (mq.size() != 0) chk_data("rnd", mq[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_reg.md
ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 Parameter: CLEAR_ON_FLUSH, 0, when 1 flush also zeroes both payload registers; when 0 payload is retained.
REQ-002 Port: clk  input  1  core clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  decode stage presents a decoded instruction.
REQ-005 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-006 Port: in_data  input  id_ex_t (160)  pc[31:0], opcode[6:0], rd[4:0], rs1[4:0], rs2[4:0], funct3[2:0], funct7[6:0], imm[31:0] (sign-extended immediate), rs1_data[31:0], rs2_data[31:0].
REQ-007 Port: flush  input  1  branch/jump redirect; kills all held and incoming instructions.
REQ-008 Port: out_valid  output  1  execute stage has a valid instruction.
REQ-009 Port: out_ready  input  1  execute stage consumes out_data this cycle.
REQ-010 Port: out_data  output  id_ex_t (160)  instruction presented to execute.

Function
REQ-011 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-012 Storage: main register (drives out_data) plus one skid register; occupancy states EMPTY, ONE, TWO.
REQ-013 in_ready shall be a registered signal equal to (state != TWO); no combinational path from out_ready to in_ready.
REQ-014 out_valid shall equal (state != EMPTY); out_data shall be driven directly from the main register.
REQ-015 EMPTY: accept -> ONE, data into main (latency 1 cycle input-to-output).
REQ-016 ONE: accept and consume -> ONE, new data into main; accept only -> TWO, new data into skid; consume only -> EMPTY.
REQ-017 TWO: in_ready=0; consume -> ONE, skid copied into main; no consume -> hold.
REQ-018 Order preserved: instructions leave in acceptance order; no duplication, no loss.
REQ-019 out_data shall remain stable while out_valid=1 and out_ready=0.
REQ-020 Flush has priority: next state EMPTY regardless of in_valid/out_ready; an instruction offered in the flush cycle is dropped; in_ready=1 the following cycle.
REQ-021 With CLEAR_ON_FLUSH=1, flush zeroes main and skid payloads; with 0, payloads hold stale values (don't-care while out_valid=0).
REQ-022 Payload fields pass unmodified; no arithmetic on imm or pc.
REQ-023 Full throughput: continuous in_valid with out_ready=1 sustains one instruction per cycle.

Reset
REQ-024 On rst assertion, state=EMPTY, out_valid=0, in_ready=1, main and skid payloads = 0, asynchronously.
REQ-025 Reset deassertion mid-stream: first transfer accepted only at the first rising edge after rst falls.

Structure
REQ-026 id_ex_t packed struct and opcode localparams (OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR) shall live in shared package rv32_pkg.
REQ-027 Occupancy state shall be an enum in rv32_pkg; block is a single module, no sub-modules.

Verification
REQ-028 Stream 8 instructions (pc=0x00..0x1C, imm=0xFFFFFFFC) with out_ready=1 -> 8 outputs, same order, one per cycle, latency 1.
REQ-029 Hold out_ready=0 for 3 cycles with in_valid=1 -> two accepted, in_ready=0 from cycle 2, out_data stable at pc=0x00; release -> pc=0x04 next, no loss.
REQ-030 flush in TWO state with in_valid=1 (pc=0x40) -> next cycle out_valid=0, in_ready=1; pc=0x40 never appears on output.
REQ-031 CLEAR_ON_FLUSH=1, flush with main pc=0x10 -> out_data all zeroes next cycle.
REQ-032 Assert rst asynchronously mid-cycle while in TWO -> out_valid=0, in_ready=1, out_data=0 before next clock edge.
REQ-033 Random in_valid/out_ready/flush 10k cycles vs scoreboard -> zero ordering/loss/duplication errors.
